// File: rtl/reg16_idu_file_pkg.sv
// Shared definitions for the 16-bit register-pair file and
// the microcode blocks that drive its select bus.
package reg16_idu_file_pkg;

  localparam int PAIR_PC    = 0;
  localparam int PAIR_BC    = 1;
  localparam int PAIR_DE    = 2;
  localparam int PAIR_HL    = 3;
  localparam int PAIR_SP    = 4;
  localparam int PAIR_WZ    = 5;
  localparam int PAIR_COUNT = 6;

  localparam logic [1:0] IDU_NONE = 2'b00;
  localparam logic [1:0] IDU_INC  = 2'b01;
  localparam logic [1:0] IDU_DEC  = 2'b11;

  // Bytes not enabled by mask keep their old contents.
  function automatic logic [15:0] merge_bytes(
    input logic [15:0] old_val,
    input logic [15:0] new_val,
    input logic [1:0]  mask
  );
    logic [15:0] r;
    r = old_val;
    if (mask[1]) r[15:8] = new_val[15:8];
    if (mask[0]) r[7:0]  = new_val[7:0];
    return r;
  endfunction

endpackage

// File: rtl/reg16_idu_file_idu16.sv
// Combinational 16-bit increment/decrement unit.
// Wraps modulo 2^16 in both directions.
module idu16 (
  input  logic [15:0] value,
  input  logic        dec,
  output logic [15:0] result
);

  always_comb begin
    result = dec ? value - 16'd1 : value + 16'd1;
  end

endmodule

// File: rtl/reg16_idu_file.sv
// Register-pair file (PC, BC, DE, HL, SP, WZ) with IDU.
// Drives the selected pair onto the address bus.
module reg16_idu_file
  import reg16_idu_file_pkg::*;
#(
  parameter logic [15:0] PC_RESET   = 16'h0000,
  parameter logic [15:0] SP_RESET   = 16'h0000,
  parameter logic [15:0] PAIR_RESET = 16'h0000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [5:0]  i_Read16,
  input  logic [5:0]  i_Write16,
  input  logic [1:0]  i_Increment16,
  input  logic [15:0] i_Data16,
  input  logic [1:0]  i_Byte_Mask,
  output logic [15:0] o_Addr16,
  output logic [15:0] o_Result16,
  output logic [15:0] o_PC,
  output logic [15:0] o_SP,
  output logic [15:0] o_HL,
  output logic        o_Sel_Error
);

  logic [15:0] pairs [PAIR_COUNT];
  logic [15:0] idu_out;
  logic [15:0] src;
  logic        multi_hot;
  logic        no_src;
  logic        sel_err;

  // Scan downwards so the lowest set index wins.
  always_comb begin
    o_Addr16 = '0;
    for (int i = PAIR_COUNT - 1; i >= 0; i--) begin
      if (i_Read16[i]) o_Addr16 = pairs[i];
    end
  end

  idu16 u_idu (
    .value  (o_Addr16),
    .dec    (i_Increment16[1]),
    .result (idu_out)
  );

  assign o_Result16 = i_Increment16[0] ? idu_out : o_Addr16;
  assign src        = i_Increment16[0] ? o_Result16 : i_Data16;

  assign multi_hot = (i_Read16 & (i_Read16 - 6'd1)) != 6'd0;
  assign no_src    = i_Increment16[0] && (i_Read16 == 6'd0)
                     && (i_Write16 != 6'd0);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < PAIR_COUNT; i++) begin
        pairs[i] <= PAIR_RESET;
      end
      pairs[PAIR_PC] <= PC_RESET;
      pairs[PAIR_SP] <= SP_RESET;
      sel_err        <= 1'b0;
    end else begin
      if (multi_hot || no_src) sel_err <= 1'b1;
      // An increment with nothing to increment blocks every write.
      for (int i = 0; i < PAIR_COUNT; i++) begin
        if (i_Write16[i] && !no_src) begin
          pairs[i] <= merge_bytes(pairs[i], src, i_Byte_Mask);
        end
      end
    end
  end

  assign o_PC        = pairs[PAIR_PC];
  assign o_SP        = pairs[PAIR_SP];
  assign o_HL        = pairs[PAIR_HL];
  assign o_Sel_Error = sel_err;

endmodule

// File: tb/tb_reg16_idu_file.sv
// Self-checking bench for reg16_idu_file with a
// behavioural pair-file model and random stimulus.
module tb_reg16_idu_file;

  localparam logic [15:0] PCR = 16'h0100;
  localparam logic [15:0] SPR = 16'hFFFE;

  logic        i_Clk;
  logic        i_Reset;
  logic [5:0]  i_Read16;
  logic [5:0]  i_Write16;
  logic [1:0]  i_Increment16;
  logic [15:0] i_Data16;
  logic [1:0]  i_Byte_Mask;
  logic [15:0] o_Addr16;
  logic [15:0] o_Result16;
  logic [15:0] o_PC;
  logic [15:0] o_SP;
  logic [15:0] o_HL;
  logic        o_Sel_Error;

  int total = 0;
  int bad   = 0;

  logic [15:0] m [6];
  logic        merr;

  reg16_idu_file #(
    .PC_RESET   (PCR),
    .SP_RESET   (SPR),
    .PAIR_RESET (16'h0000)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_Read16      (i_Read16),
    .i_Write16     (i_Write16),
    .i_Increment16 (i_Increment16),
    .i_Data16      (i_Data16),
    .i_Byte_Mask   (i_Byte_Mask),
    .o_Addr16      (o_Addr16),
    .o_Result16    (o_Result16),
    .o_PC          (o_PC),
    .o_SP          (o_SP),
    .o_HL          (o_HL),
    .o_Sel_Error   (o_Sel_Error)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  function automatic void m_reset();
    for (int i = 0; i < 6; i++) m[i] = 16'h0000;
    m[0] = PCR;
    m[4] = SPR;
    merr = 1'b0;
  endfunction

  function automatic logic [15:0] m_addr();
    for (int i = 0; i < 6; i++)
      if (i_Read16[i]) return m[i];
    return 16'h0000;
  endfunction

  function automatic logic [15:0] m_result();
    logic [15:0] a;
    a = m_addr();
    if (!i_Increment16[0]) return a;
    return i_Increment16[1] ? 16'(a - 16'd1) : 16'(a + 16'd1);
  endfunction

  function automatic void m_clock();
    logic [15:0] s;
    logic        ill;
    s = i_Increment16[0] ? m_result() : i_Data16;
    ill = i_Increment16[0] && i_Read16 == 0 && i_Write16 != 0;
    if (ill || $countones(i_Read16) > 1) merr = 1'b1;
    if (!ill) begin
      for (int i = 0; i < 6; i++) begin
        if (i_Write16[i]) begin
          if (i_Byte_Mask[1]) m[i][15:8] = s[15:8];
          if (i_Byte_Mask[0]) m[i][7:0]  = s[7:0];
        end
      end
    end
  endfunction

  task automatic drive(input logic [5:0] rd, input logic [5:0] wr,
                       input logic [1:0] inc, input logic [15:0] d,
                       input logic [1:0] mk);
    @(negedge i_Clk);
    i_Read16 = rd; i_Write16 = wr; i_Increment16 = inc;
    i_Data16 = d; i_Byte_Mask = mk;
    #1;
  endtask

  task automatic tick();
    @(posedge i_Clk);
    m_clock();
    #1;
  endtask

  task automatic idle();
    i_Read16 = 0; i_Write16 = 0; i_Increment16 = 0;
    i_Data16 = 0; i_Byte_Mask = 0;
  endtask

  task automatic load(input int p, input logic [15:0] v);
    drive(6'd0, 6'(1 << p), 2'b00, v, 2'b11);
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_Clk);
    #1;
    total++;
    if (o_PC !== PCR) begin bad++;
      $display("FAIL reset_pc got=%h exp=%h", o_PC, PCR); end
    total++;
    if (o_SP !== SPR) begin bad++;
      $display("FAIL reset_sp got=%h exp=%h", o_SP, SPR); end
    total++;
    if (o_Sel_Error !== 1'b0) begin bad++;
      $display("FAIL reset_err got=%b exp=0", o_Sel_Error); end
    @(negedge i_Clk);
    i_Reset = 0;
    load(0, 16'h1234);
    load(4, 16'h4321);
    total++;
    if (o_PC !== 16'h1234) begin bad++;
      $display("FAIL pre_reset_pc got=%h exp=1234", o_PC); end
    #2 i_Reset = 1;
    #1;
    m_reset();
    total++;
    if (o_PC !== PCR || o_SP !== SPR) begin bad++;
      $display("FAIL async_reset pc=%h sp=%h exp=%h %h",
               o_PC, o_SP, PCR, SPR); end
    total++;
    if (o_Sel_Error !== 1'b0) begin bad++;
      $display("FAIL async_reset_err got=%b exp=0", o_Sel_Error); end
    @(negedge i_Clk);
    i_Reset = 0; idle();
  endtask

  task automatic test_inc_wrap();
    load(1, 16'hFFFF);
    drive(6'b000010, 6'b000010, 2'b01, 16'h5A5A, 2'b11);
    total++;
    if (o_Result16 !== 16'h0000) begin bad++;
      $display("FAIL inc_wrap_result got=%h exp=0000", o_Result16); end
    tick();
    drive(6'b000010, 6'd0, 2'b00, 16'h0, 2'b00);
    total++;
    if (o_Addr16 !== 16'h0000) begin bad++;
      $display("FAIL inc_wrap_bc got=%h exp=0000", o_Addr16); end
    total++;
    if (o_Sel_Error !== 1'b0) begin bad++;
      $display("FAIL inc_wrap_err got=%b exp=0", o_Sel_Error); end
    tick();
  endtask

  task automatic test_dec_sp();
    logic [15:0] exp_sp [2];
    exp_sp[0] = 16'hFFFF;
    exp_sp[1] = 16'hFFFE;
    load(4, 16'h0000);
    for (int k = 0; k < 2; k++) begin
      drive(6'b010000, 6'b010000, 2'b11, 16'h0, 2'b11);
      tick();
      total++;
      if (o_SP !== exp_sp[k]) begin bad++;
        $display("FAIL dec_sp_%0d got=%h exp=%h", k, o_SP, exp_sp[k]); end
    end
  endtask

  task automatic test_byte_mask();
    load(3, 16'h1234);
    drive(6'd0, 6'b001000, 2'b00, 16'hABCD, 2'b10);
    tick();
    total++;
    if (o_HL !== 16'hAB34) begin bad++;
      $display("FAIL mask_hi got=%h exp=AB34", o_HL); end
    drive(6'd0, 6'b001000, 2'b00, 16'h5678, 2'b01);
    tick();
    total++;
    if (o_HL !== 16'hAB78) begin bad++;
      $display("FAIL mask_lo got=%h exp=AB78", o_HL); end
    drive(6'd0, 6'b001000, 2'b00, 16'hFFFF, 2'b00);
    tick();
    total++;
    if (o_HL !== 16'hAB78) begin bad++;
      $display("FAIL mask_none got=%h exp=AB78", o_HL); end
  endtask

  task automatic test_illegal();
    logic [15:0] pc0, sp0, hl0;
    load(1, 16'h1111);
    load(2, 16'h2222);
    drive(6'b000110, 6'b000100, 2'b01, 16'h0, 2'b11);
    tick();
    drive(6'b000100, 6'd0, 2'b00, 16'h0, 2'b00);
    total++;
    if (o_Addr16 !== 16'h1112) begin bad++;
      $display("FAIL multi_read_de got=%h exp=1112", o_Addr16); end
    total++;
    if (o_Sel_Error !== 1'b1) begin bad++;
      $display("FAIL multi_read_err got=%b exp=1", o_Sel_Error); end
    tick();
    pc0 = o_PC; sp0 = o_SP; hl0 = o_HL;
    drive(6'd0, 6'b111111, 2'b01, 16'hDEAD, 2'b11);
    tick();
    total++;
    if (o_PC !== pc0 || o_SP !== sp0 || o_HL !== hl0) begin bad++;
      $display("FAIL no_src_write pc=%h sp=%h hl=%h exp=%h %h %h",
               o_PC, o_SP, o_HL, pc0, sp0, hl0); end
    drive(6'b000010, 6'd0, 2'b00, 16'h0, 2'b00);
    total++;
    if (o_Addr16 !== 16'h1111) begin bad++;
      $display("FAIL no_src_bc got=%h exp=1111", o_Addr16); end
    total++;
    if (o_Sel_Error !== 1'b1) begin bad++;
      $display("FAIL err_sticky got=%b exp=1", o_Sel_Error); end
    tick();
  endtask

  task automatic test_read_during_write();
    logic [15:0] exp_a;
    load(0, 16'h0050);
    for (int k = 0; k < 3; k++) begin
      drive(6'b000001, 6'b000001, 2'b01, 16'h0, 2'b11);
      exp_a = 16'(16'h0050 + k);
      total++;
      if (o_Addr16 !== exp_a) begin bad++;
        $display("FAIL rdw_addr_%0d got=%h exp=%h", k, o_Addr16, exp_a); end
      tick();
    end
    total++;
    if (o_PC !== 16'h0053) begin bad++;
      $display("FAIL rdw_final got=%h exp=0053", o_PC); end
    load(0, 16'h0050);
    drive(6'b000001, 6'b000001, 2'b01, 16'h0, 2'b11);
    tick();
    drive(6'b000001, 6'b000001, 2'b01, 16'h0, 2'b11);
    #1 i_Reset = 1;
    @(posedge i_Clk);
    #1;
    m_reset();
    total++;
    if (o_PC !== PCR) begin bad++;
      $display("FAIL rdw_reset_pc got=%h exp=%h", o_PC, PCR); end
    total++;
    if (o_Sel_Error !== 1'b0) begin bad++;
      $display("FAIL rdw_reset_err got=%b exp=0", o_Sel_Error); end
    @(negedge i_Clk);
    i_Reset = 0; idle();
  endtask

  task automatic test_random();
    logic [5:0] rd;
    int r;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) rd = 6'd0;
      else if (r <= 6) rd = 6'(1 << (r - 1));
      else rd = 6'($urandom);
      drive(rd, 6'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            2'($urandom), 16'($urandom), 2'($urandom));
      total++;
      if (o_Addr16 !== m_addr() || o_Result16 !== m_result()) begin bad++;
        $display("FAIL rnd_comb_%0d addr=%h res=%h exp=%h %h", n,
                 o_Addr16, o_Result16, m_addr(), m_result()); end
      tick();
      total++;
      if (o_PC !== m[0] || o_SP !== m[4] || o_HL !== m[3]
          || o_Sel_Error !== merr) begin bad++;
        $display("FAIL rnd_reg_%0d pc=%h sp=%h hl=%h e=%b exp=%h %h %h %b",
                 n, o_PC, o_SP, o_HL, o_Sel_Error, m[0], m[4], m[3], merr);
      end
    end
  endtask

  initial begin
    i_Reset = 1;
    idle();
    m_reset();
    test_reset();
    test_inc_wrap();
    test_dec_sp();
    test_byte_mask();
    test_illegal();
    test_read_during_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
